// File: rtl/acc_order_pkg.sv
// Shared types and defaults for the scalar/vector memory-ordering controller.
package acc_order_pkg;

    localparam int unsigned MaxStoresDef         = 7;
    localparam int unsigned MaxAccOutstandingDef = 4;

    // Ownership of the memory port: scalar pipe, draining scalar stores,
    // vector unit, draining vector ops.
    typedef enum logic [1:0] {
        StScalar   = 2'd0,
        StDrain    = 2'd1,
        StAcc      = 2'd2,
        StAccDrain = 2'd3
    } acc_order_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/acc_mem_order_ctrl_if.sv
// Handshake/status bundle between the core and the memory-ordering controller.
// Signal suffixes are from the controller's point of view.
interface acc_mem_order_ctrl_if #(
    parameter int unsigned CntW = $clog2(acc_order_pkg::max_u(
        acc_order_pkg::MaxStoresDef, acc_order_pkg::MaxAccOutstandingDef) + 1)
);
    logic            st_issue_i;
    logic            st_ack_i;
    logic            acc_req_valid_i;
    logic            acc_req_ready_o;
    logic            acc_done_i;
    logic            scalar_mem_stall_o;
    logic [CntW-1:0] st_cnt_o;
    logic [CntW-1:0] acc_cnt_o;
    logic            err_o;
    logic [31:0]     stall_cycles_o;

    modport master (
        output st_issue_i, st_ack_i, acc_req_valid_i, acc_done_i,
        input  acc_req_ready_o, scalar_mem_stall_o, st_cnt_o, acc_cnt_o, err_o,
               stall_cycles_o
    );

    modport slave (
        input  st_issue_i, st_ack_i, acc_req_valid_i, acc_done_i,
        output acc_req_ready_o, scalar_mem_stall_o, st_cnt_o, acc_cnt_o, err_o,
               stall_cycles_o
    );

endinterface

// File: rtl/acc_order_cnt.sv
// Saturating up/down in-flight counter. Simultaneous inc/dec leaves the count
// unchanged; a lone inc at Max or lone dec at 0 holds the count and raises
// o_err for that cycle. o_cnt_next exposes the value loaded on the next edge.
module acc_order_cnt #(
    parameter int unsigned Max   = 7,
    parameter int unsigned Width = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [Width-1:0] o_cnt,
    output logic [Width-1:0] o_cnt_next,
    output logic             o_err
);

    localparam logic [Width-1:0] MaxVal = Width'(Max);

    logic [Width-1:0] r_cnt;
    logic [Width-1:0] w_cnt_next;
    logic             w_err;

    // Next count with bound checks
    always_comb begin
        w_cnt_next = r_cnt;
        w_err      = 1'b0;
        case ({i_inc, i_dec})
            2'b10: begin
                if (r_cnt == MaxVal) w_err = 1'b1;
                else                 w_cnt_next = r_cnt + 1'b1;
            end
            2'b01: begin
                if (r_cnt == '0) w_err = 1'b1;
                else             w_cnt_next = r_cnt - 1'b1;
            end
            default: ;
        endcase
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_cnt <= '0;
        else         r_cnt <= w_cnt_next;
    end

    assign o_cnt      = r_cnt;
    assign o_cnt_next = w_cnt_next;
    assign o_err      = w_err;

endmodule

// File: rtl/acc_mem_order_ctrl.sv
// Memory-ordering controller between the scalar store path and a vector unit.
// Scalar stores must drain before vector memory ops start, and vector ops must
// drain before scalar accesses resume.
// Optional feature: define ACC_ORDER_STALL_CNT_EN to build a saturating
// counter of stalled cycles on stall_cycles_o (tied to 0 otherwise).
module acc_mem_order_ctrl
    import acc_order_pkg::*;
#(
    parameter int unsigned MaxStores         = MaxStoresDef,
    parameter int unsigned MaxAccOutstanding = MaxAccOutstandingDef,
    parameter int unsigned CntW              = $clog2(max_u(MaxStores, MaxAccOutstanding) + 1)
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    acc_mem_order_ctrl_if.slave bus
);

    localparam logic [CntW-1:0] AccMax = CntW'(MaxAccOutstanding);

    acc_order_state_e r_state;
    acc_order_state_e w_state_next;

    logic [CntW-1:0] w_st_cnt;
    logic [CntW-1:0] w_st_cnt_next;
    logic [CntW-1:0] w_acc_cnt;
    logic [CntW-1:0] w_acc_cnt_next;
    logic            w_st_err;
    logic            w_acc_err;
    logic            w_ready;
    logic            w_stall;
    logic            w_accept;
    logic            w_issue_err;
    logic            r_err;

    assign w_accept = bus.acc_req_valid_i & w_ready;

    acc_order_cnt #(
        .Max   (MaxStores),
        .Width (CntW)
    ) u_st_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_inc      (bus.st_issue_i),
        .i_dec      (bus.st_ack_i),
        .o_cnt      (w_st_cnt),
        .o_cnt_next (w_st_cnt_next),
        .o_err      (w_st_err)
    );

    acc_order_cnt #(
        .Max   (MaxAccOutstanding),
        .Width (CntW)
    ) u_acc_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .i_inc      (w_accept),
        .i_dec      (bus.acc_done_i),
        .o_cnt      (w_acc_cnt),
        .o_cnt_next (w_acc_cnt_next),
        .o_err      (w_acc_err)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= StScalar;
        else         r_state <= w_state_next;
    end

    // Next-state: drain stores on entry, drain vector ops on exit
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StScalar: begin
                if (bus.acc_req_valid_i) w_state_next = StDrain;
            end
            StDrain: begin
                // Committed once entered; a dropped valid does not cancel.
                if (w_st_cnt_next == '0) w_state_next = StAcc;
            end
            StAcc: begin
                if (!bus.acc_req_valid_i) w_state_next = StAccDrain;
            end
            StAccDrain: begin
                if (bus.acc_req_valid_i)      w_state_next = StAcc;
                else if (w_acc_cnt_next == '0) w_state_next = StScalar;
            end
            default: w_state_next = StScalar;
        endcase
    end

    // Moore stall and valid-independent ready
    always_comb begin
        w_stall = (r_state != StScalar);
        w_ready = (r_state == StAcc) && (w_acc_cnt < AccMax);
    end

    // A scalar store slipping past the stall is still counted but is a protocol error.
    assign w_issue_err = bus.st_issue_i & w_stall;

    // Sticky error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_err <= 1'b0;
        else         r_err <= r_err | w_st_err | w_acc_err | w_issue_err;
    end

`ifdef ACC_ORDER_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    // Saturating stall-cycle counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.stall_cycles_o = r_stall_cycles;
`else
    assign bus.stall_cycles_o = '0;
`endif

    assign bus.acc_req_ready_o    = w_ready;
    assign bus.scalar_mem_stall_o = w_stall;
    assign bus.st_cnt_o           = w_st_cnt;
    assign bus.acc_cnt_o          = w_acc_cnt;
    assign bus.err_o              = r_err;

endmodule

// File: tb/tb_acc_mem_order_ctrl.sv
// Self-checking bench for acc_mem_order_ctrl: directed scenarios plus a
// randomized run checked against a cycle-level behavioural model.
module tb_acc_mem_order_ctrl;

    localparam int MAX_ST  = 7;
    localparam int MAX_ACC = 4;
    localparam int CNTW    = 3;

    localparam int PH_SCALAR    = 0;
    localparam int PH_DRAIN     = 1;
    localparam int PH_ACC       = 2;
    localparam int PH_ACC_DRAIN = 3;

`ifdef ACC_ORDER_STALL_CNT_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clk;
    logic rst_ni;

    int n_cmp;
    int n_fail;

    // Behavioural model
    int          m_phase;
    int          m_st;
    int          m_acc;
    bit          m_err;
    logic [31:0] m_stall_cycles;

    acc_mem_order_ctrl_if #(.CntW(CNTW)) bus ();

    acc_mem_order_ctrl #(
        .MaxStores         (MAX_ST),
        .MaxAccOutstanding (MAX_ACC),
        .CntW              (CNTW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit model_ready();
        return (m_phase == PH_ACC) && (m_acc < MAX_ACC);
    endfunction

    function automatic bit model_stall();
        return m_phase != PH_SCALAR;
    endfunction

    task automatic model_clear();
        m_phase        = PH_SCALAR;
        m_st           = 0;
        m_acc          = 0;
        m_err          = 1'b0;
        m_stall_cycles = '0;
    endtask

    task automatic drive_idle();
        bus.st_issue_i      = 1'b0;
        bus.st_ack_i        = 1'b0;
        bus.acc_req_valid_i = 1'b0;
        bus.acc_done_i      = 1'b0;
    endtask

    // Leaves time at posedge+1 with reset released.
    task automatic apply_reset();
        drive_idle();
        rst_ni = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        model_clear();
    endtask

    // One clock: apply inputs, advance the model by the spec rules, sample at posedge+1.
    task automatic cycle(input bit issue, input bit ack, input bit valid, input bit done);
        int          st_n;
        int          acc_n;
        int          ph_n;
        bit          err_n;
        bit          take;
        logic [31:0] sc_n;
        bus.st_issue_i      = issue;
        bus.st_ack_i        = ack;
        bus.acc_req_valid_i = valid;
        bus.acc_done_i      = done;
        take  = valid && model_ready();
        err_n = m_err;
        st_n  = m_st + int'(issue) - int'(ack);
        if (st_n < 0 || st_n > MAX_ST) begin
            err_n = 1'b1;
            st_n  = m_st;
        end
        if (issue && model_stall()) err_n = 1'b1;
        acc_n = m_acc + int'(take) - int'(done);
        if (acc_n < 0 || acc_n > MAX_ACC) begin
            err_n = 1'b1;
            acc_n = m_acc;
        end
        sc_n = m_stall_cycles;
        if (STALL_EN && model_stall() && sc_n != 32'hFFFF_FFFF) sc_n = sc_n + 1;
        ph_n = m_phase;
        if (m_phase == PH_SCALAR && valid)     ph_n = PH_DRAIN;
        if (m_phase == PH_DRAIN && st_n == 0)  ph_n = PH_ACC;
        if (m_phase == PH_ACC && !valid)       ph_n = PH_ACC_DRAIN;
        if (m_phase == PH_ACC_DRAIN) begin
            if (valid)           ph_n = PH_ACC;
            else if (acc_n == 0) ph_n = PH_SCALAR;
        end
        @(posedge clk);
        #1;
        m_phase        = ph_n;
        m_st           = st_n;
        m_acc          = acc_n;
        m_err          = err_n;
        m_stall_cycles = sc_n;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_ni = 1'b0;
        #3;
        n_cmp++; if (bus.st_cnt_o !== 3'd0) begin n_fail++; $display("FAIL reset_st_cnt: got %0d want 0", bus.st_cnt_o); end
        n_cmp++; if (bus.acc_cnt_o !== 3'd0) begin n_fail++; $display("FAIL reset_acc_cnt: got %0d want 0", bus.acc_cnt_o); end
        n_cmp++; if (bus.acc_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.acc_req_ready_o); end
        n_cmp++; if (bus.scalar_mem_stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.scalar_mem_stall_o); end
        n_cmp++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
        n_cmp++; if (bus.stall_cycles_o !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cycles: got %0d want 0", bus.stall_cycles_o); end
        apply_reset();
    endtask

    task automatic test_min_latency();
        apply_reset();
        cycle(0, 0, 1, 0);
        n_cmp++; if (bus.acc_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL lat_drain_ready: got %b want 0", bus.acc_req_ready_o); end
        n_cmp++; if (bus.scalar_mem_stall_o !== 1'b1) begin n_fail++; $display("FAIL lat_drain_stall: got %b want 1", bus.scalar_mem_stall_o); end
        cycle(0, 0, 1, 0);
        n_cmp++; if (bus.acc_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL lat_acc_ready: got %b want 1", bus.acc_req_ready_o); end
    endtask

    task automatic test_drain_handoff();
        apply_reset();
        repeat (3) cycle(1, 0, 0, 0);
        n_cmp++; if (bus.st_cnt_o !== 3'd3) begin n_fail++; $display("FAIL drain_st3: got %0d want 3", bus.st_cnt_o); end
        n_cmp++; if (bus.scalar_mem_stall_o !== 1'b0) begin n_fail++; $display("FAIL drain_prestall: got %b want 0", bus.scalar_mem_stall_o); end
        cycle(0, 0, 1, 0);
        n_cmp++; if (bus.scalar_mem_stall_o !== 1'b1) begin n_fail++; $display("FAIL drain_stall: got %b want 1", bus.scalar_mem_stall_o); end
        n_cmp++; if (bus.acc_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL drain_ready: got %b want 0", bus.acc_req_ready_o); end
        cycle(0, 1, 1, 0);
        cycle(0, 1, 0, 0);  // valid dropped while draining
        n_cmp++; if (bus.scalar_mem_stall_o !== 1'b1) begin n_fail++; $display("FAIL drain_hold_stall: got %b want 1", bus.scalar_mem_stall_o); end
        n_cmp++; if (bus.st_cnt_o !== 3'd1) begin n_fail++; $display("FAIL drain_st1: got %0d want 1", bus.st_cnt_o); end
        cycle(0, 1, 1, 0);
        n_cmp++; if (bus.st_cnt_o !== 3'd0) begin n_fail++; $display("FAIL drain_st0: got %0d want 0", bus.st_cnt_o); end
        n_cmp++; if (bus.acc_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL drain_acc_ready: got %b want 1", bus.acc_req_ready_o); end
        n_cmp++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL drain_err: got %b want 0", bus.err_o); end
    endtask

    task automatic test_acc_window();
        apply_reset();
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        repeat (4) cycle(0, 0, 1, 0);
        n_cmp++; if (bus.acc_cnt_o !== 3'd4) begin n_fail++; $display("FAIL win_cnt4: got %0d want 4", bus.acc_cnt_o); end
        n_cmp++; if (bus.acc_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL win_full_ready: got %b want 0", bus.acc_req_ready_o); end
        cycle(0, 0, 1, 1);
        n_cmp++; if (bus.acc_cnt_o !== 3'd3) begin n_fail++; $display("FAIL win_cnt3: got %0d want 3", bus.acc_cnt_o); end
        n_cmp++; if (bus.acc_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL win_ready_again: got %b want 1", bus.acc_req_ready_o); end
        cycle(0, 0, 1, 1);  // accept and done together
        n_cmp++; if (bus.acc_cnt_o !== 3'd3) begin n_fail++; $display("FAIL win_both: got %0d want 3", bus.acc_cnt_o); end
        n_cmp++; if (bus.err_o !== 1'b0) begin n_fail++; $display("FAIL win_err: got %b want 0", bus.err_o); end
    endtask

    task automatic test_acc_drain_return();
        apply_reset();
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        repeat (2) cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        n_cmp++; if (bus.acc_cnt_o !== 3'd2) begin n_fail++; $display("FAIL ad_cnt2: got %0d want 2", bus.acc_cnt_o); end
        n_cmp++; if (bus.acc_req_ready_o !== 1'b0) begin n_fail++; $display("FAIL ad_ready: got %b want 0", bus.acc_req_ready_o); end
        cycle(0, 0, 1, 0);  // back to ACC, nothing accepted from ACC_DRAIN
        n_cmp++; if (bus.acc_req_ready_o !== 1'b1) begin n_fail++; $display("FAIL ad_reenter_ready: got %b want 1", bus.acc_req_ready_o); end
        n_cmp++; if (bus.acc_cnt_o !== 3'd2) begin n_fail++; $display("FAIL ad_reenter_cnt: got %0d want 2", bus.acc_cnt_o); end
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        n_cmp++; if (bus.scalar_mem_stall_o !== 1'b1) begin n_fail++; $display("FAIL ad_mid_stall: got %b want 1", bus.scalar_mem_stall_o); end
        cycle(0, 0, 0, 1);
        n_cmp++; if (bus.scalar_mem_stall_o !== 1'b0) begin n_fail++; $display("FAIL ad_scalar_stall: got %b want 0", bus.scalar_mem_stall_o); end
        n_cmp++; if (bus.acc_cnt_o !== 3'd0) begin n_fail++; $display("FAIL ad_cnt0: got %0d want 0", bus.acc_cnt_o); end
    endtask

    task automatic test_store_bounds();
        apply_reset();
        cycle(1, 1, 0, 0);
        n_cmp++; if (bus.st_cnt_o !== 3'd0 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL sb_both_at0: got cnt=%0d err=%b want cnt=0 err=0", bus.st_cnt_o, bus.err_o); end
        repeat (7) cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        n_cmp++; if (bus.st_cnt_o !== 3'd7 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL sb_both_at7: got cnt=%0d err=%b want cnt=7 err=0", bus.st_cnt_o, bus.err_o); end
        cycle(1, 0, 0, 0);
        n_cmp++; if (bus.st_cnt_o !== 3'd7 || bus.err_o !== 1'b1) begin n_fail++; $display("FAIL sb_over: got cnt=%0d err=%b want cnt=7 err=1", bus.st_cnt_o, bus.err_o); end
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        n_cmp++; if (bus.st_cnt_o !== 3'd5 || bus.err_o !== 1'b1) begin n_fail++; $display("FAIL sb_sticky: got cnt=%0d err=%b want cnt=5 err=1", bus.st_cnt_o, bus.err_o); end
        apply_reset();
        cycle(0, 1, 0, 0);
        n_cmp++; if (bus.st_cnt_o !== 3'd0 || bus.err_o !== 1'b1) begin n_fail++; $display("FAIL sb_under: got cnt=%0d err=%b want cnt=0 err=1", bus.st_cnt_o, bus.err_o); end
        apply_reset();
        cycle(0, 0, 1, 0);
        cycle(1, 0, 1, 0);  // store slips in while stalled
        n_cmp++; if (bus.st_cnt_o !== 3'd1 || bus.err_o !== 1'b1) begin n_fail++; $display("FAIL sb_stalled_issue: got cnt=%0d err=%b want cnt=1 err=1", bus.st_cnt_o, bus.err_o); end
    endtask

    task automatic test_reset_mid_acc();
        apply_reset();
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        repeat (3) cycle(0, 0, 1, 0);
        n_cmp++; if (bus.acc_cnt_o !== 3'd3) begin n_fail++; $display("FAIL rm_pre_cnt: got %0d want 3", bus.acc_cnt_o); end
        #2;
        drive_idle();
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (bus.acc_cnt_o !== 3'd0 || bus.st_cnt_o !== 3'd0) begin n_fail++; $display("FAIL rm_cnts: got acc=%0d st=%0d want 0 0", bus.acc_cnt_o, bus.st_cnt_o); end
        n_cmp++; if (bus.acc_req_ready_o !== 1'b0 || bus.scalar_mem_stall_o !== 1'b0) begin n_fail++; $display("FAIL rm_hs: got ready=%b stall=%b want 0 0", bus.acc_req_ready_o, bus.scalar_mem_stall_o); end
        n_cmp++; if (bus.err_o !== 1'b0 || bus.stall_cycles_o !== 32'd0) begin n_fail++; $display("FAIL rm_err: got err=%b sc=%0d want 0 0", bus.err_o, bus.stall_cycles_o); end
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        model_clear();
        cycle(0, 0, 0, 0);
        n_cmp++; if (bus.scalar_mem_stall_o !== 1'b0 || bus.err_o !== 1'b0) begin n_fail++; $display("FAIL rm_resume: got stall=%b err=%b want 0 0", bus.scalar_mem_stall_o, bus.err_o); end
    endtask

    task automatic test_stall_count();
        logic [31:0] exp_sc;
        exp_sc = STALL_EN ? 32'd10 : 32'd0;
        apply_reset();
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        repeat (7) cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        n_cmp++; if (bus.scalar_mem_stall_o !== 1'b0) begin n_fail++; $display("FAIL sc_end_stall: got %b want 0", bus.scalar_mem_stall_o); end
        n_cmp++; if (bus.stall_cycles_o !== exp_sc) begin n_fail++; $display("FAIL sc_count: got %0d want %0d", bus.stall_cycles_o, exp_sc); end
    endtask

    task automatic test_random();
        bit issue, ack, valid, done;
        valid = 1'b0;
        for (int blk = 0; blk < 6; blk++) begin
            apply_reset();
            for (int c = 0; c < 60; c++) begin
                if (model_stall()) issue = ($urandom_range(0, 99) < 3);
                else               issue = ($urandom_range(0, 99) < 40);
                ack  = (m_st > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 3);
                done = (m_acc > 0) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 2);
                if ($urandom_range(0, 99) < 20) valid = ~valid;
                cycle(issue, ack, valid, done);
                n_cmp++;
                if (bus.st_cnt_o !== CNTW'(m_st) || bus.acc_cnt_o !== CNTW'(m_acc)
                    || bus.acc_req_ready_o !== model_ready()
                    || bus.scalar_mem_stall_o !== model_stall()
                    || bus.err_o !== m_err || bus.stall_cycles_o !== m_stall_cycles) begin
                    n_fail++;
                    $display("FAIL rand[%0d.%0d]: got st=%0d acc=%0d rdy=%b stall=%b err=%b sc=%0d want st=%0d acc=%0d rdy=%b stall=%b err=%b sc=%0d",
                             blk, c, bus.st_cnt_o, bus.acc_cnt_o, bus.acc_req_ready_o,
                             bus.scalar_mem_stall_o, bus.err_o, bus.stall_cycles_o,
                             m_st, m_acc, model_ready(), model_stall(), m_err, m_stall_cycles);
                end
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        model_clear();
        test_reset();
        test_min_latency();
        test_drain_handoff();
        test_acc_window();
        test_acc_drain_return();
        test_store_bounds();
        test_reset_mid_acc();
        test_stall_count();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
